// File: rtl/rr_mux4_pkg.sv
// rr_mux4_pkg: shared constants and types for the 4-to-1 round-robin mux.
// The source index encoding is shared with the downstream 1-to-4 demux.
package rr_mux4_pkg;

  localparam int unsigned WIDTH = 8;  // data width of every channel
  localparam int unsigned NSRC  = 4;  // number of sources, fixed
  localparam int unsigned SEL_W = 2;  // width of a source index

  localparam logic [SEL_W-1:0] SRC_A = 2'd0;
  localparam logic [SEL_W-1:0] SRC_B = 2'd1;
  localparam logic [SEL_W-1:0] SRC_C = 2'd2;
  localparam logic [SEL_W-1:0] SRC_D = 2'd3;

  // Output register occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ostate_e;

  // Next priority pointer: the source after the granted one, wrapping 3 -> 0
  function automatic logic [SEL_W-1:0] ptr_next(input logic [SEL_W-1:0] idx);
    return idx + SEL_W'(1);
  endfunction

endpackage

// File: rtl/rr_mux4_if.sv
// rr_mux4_if: handshake bundle of the round-robin mux.
//   a/b/c/d_valid, a/b/c/d_data : source beats toward the mux
//   a/b/c/d_ready               : per-source accept from the mux
//   y_valid, y_data, y_sel      : merged output beat and its source index
//   y_ready                     : downstream accept
// master = sources plus sink (the environment), slave = the mux itself.
interface rr_mux4_if;
  import rr_mux4_pkg::*;

  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             c_valid;
  logic [WIDTH-1:0] c_data;
  logic             c_ready;
  logic             d_valid;
  logic [WIDTH-1:0] d_data;
  logic             d_ready;
  logic             y_valid;
  logic [WIDTH-1:0] y_data;
  logic [SEL_W-1:0] y_sel;
  logic             y_ready;

  modport master (
    output a_valid, a_data, b_valid, b_data, c_valid, c_data, d_valid, d_data,
    input  a_ready, b_ready, c_ready, d_ready,
    input  y_valid, y_data, y_sel,
    output y_ready
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, c_valid, c_data, d_valid, d_data,
    output a_ready, b_ready, c_ready, d_ready,
    output y_valid, y_data, y_sel,
    input  y_ready
  );

endinterface

// File: rtl/rr_arb4.sv
// rr_arb4: combinational 4-way round-robin arbiter.
//   req     : request vector, bit i = source i
//   ptr     : highest-priority source index
//   gnt     : one-hot grant (zero when nothing requests)
//   gnt_idx : index of the granted source
//   any_req : at least one request present
module rr_arb4
  import rr_mux4_pkg::*;
(
  input  logic [NSRC-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [NSRC-1:0]  gnt,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any_req
);

  logic             found;
  logic [SEL_W-1:0] idx;

  // Scan ptr, ptr+1, ... (wrapping) and take the first requester
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = ptr;
    for (int unsigned i = 0; i < NSRC; i++) begin
      idx = ptr + SEL_W'(i);
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    if (found) gnt[gnt_idx] = 1'b1;
  end

  assign any_req = |req;

endmodule

// File: rtl/rr_mux4.sv
// rr_mux4: four-source round-robin multiplexer with one registered output stage.
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : slave side of rr_mux4_if (sources A-D in, tagged beat y out)
// Each output beat carries y_sel, the index of the source it came from.
module rr_mux4
  import rr_mux4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  rr_mux4_if.slave   bus
);

  ostate_e          state;
  ostate_e          state_nxt;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] ptr_q;

  logic [NSRC-1:0]  req;
  logic [NSRC-1:0]  gnt;
  logic [SEL_W-1:0] gnt_idx;
  logic             any_req;
  logic             can_accept;
  logic             load;
  logic [WIDTH-1:0] gnt_data;

  assign req = {bus.d_valid, bus.c_valid, bus.b_valid, bus.a_valid};

  rr_arb4 u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  // Payload of the granted source
  always_comb begin
    gnt_data = bus.a_data;
    case (gnt_idx)
      SRC_A:   gnt_data = bus.a_data;
      SRC_B:   gnt_data = bus.b_data;
      SRC_C:   gnt_data = bus.c_data;
      SRC_D:   gnt_data = bus.d_data;
      default: gnt_data = bus.a_data;
    endcase
  end

  // Output slot is free this cycle if empty or being drained; never during reset
  assign can_accept = rst_n && ((state == ST_EMPTY) || bus.y_ready);
  assign load       = can_accept && any_req;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_EMPTY;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (load) state_nxt = ST_FULL;
      ST_FULL:  if (bus.y_ready && !any_req) state_nxt = ST_EMPTY;
      default:  state_nxt = ST_EMPTY;
    endcase
  end

  // Output beat and priority pointer; a held beat is dropped by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q <= '0;
      sel_q  <= SRC_A;
      ptr_q  <= SRC_A;
    end else if (load) begin
      data_q <= gnt_data;
      sel_q  <= gnt_idx;
      ptr_q  <= ptr_next(gnt_idx);
    end
  end

  // Outputs; ready goes only to the granted source
  always_comb begin
    bus.y_valid = (state == ST_FULL);
    bus.y_data  = data_q;
    bus.y_sel   = sel_q;
    {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready} = can_accept ? gnt : '0;
  end

endmodule

// File: tb/tb_rr_mux4.sv
// tb_rr_mux4: directed bench for rr_mux4 with a cycle-level reference model.
module tb_rr_mux4;
  import rr_mux4_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sv[4];
  logic [7:0] sd[4];
  logic       yr;

  int errors = 0;
  int checks = 0;

  rr_mux4_if bus();

  rr_mux4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.a_valid = sv[0];
  assign bus.a_data  = sd[0];
  assign bus.b_valid = sv[1];
  assign bus.b_data  = sd[1];
  assign bus.c_valid = sv[2];
  assign bus.c_data  = sd[2];
  assign bus.d_valid = sv[3];
  assign bus.d_data  = sd[3];
  assign bus.y_ready = yr;

  logic [3:0] rdy;
  assign rdy = {bus.d_ready, bus.c_ready, bus.b_ready, bus.a_ready};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: output slot contents plus the priority pointer
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = 8'h00;
  int         m_sel   = 0;
  int         m_ptr   = 0;
  bit         m_live  = 1'b0;

  // First valid source at or after p, wrapping; -1 when none
  function automatic int pick(input int p);
    for (int k = 0; k < 4; k++) begin
      if (sv[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int g;
    m_live = 1'b1;
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      m_sel   = 0;
      m_ptr   = 0;
    end else begin
      g = pick(m_ptr);
      if ((!m_valid || yr) && g >= 0) begin
        m_valid = 1'b1;
        m_data  = sd[g];
        m_sel   = g;
        m_ptr   = (g + 1) % 4;
      end else if (m_valid && yr) begin
        m_valid = 1'b0;
      end
    end
  end

  // Compare every cycle, midway between edges
  always @(negedge clk) begin
    logic [3:0] exp_rdy;
    int g;
    if (m_live) begin
      exp_rdy = 4'b0000;
      g = pick(m_ptr);
      if (rst_n && (!m_valid || yr) && g >= 0) exp_rdy[g] = 1'b1;
      check("model_ready", 32'(rdy), 32'(exp_rdy));
      check("model_y_valid", 32'(bus.y_valid), 32'(m_valid));
      if (m_valid) begin
        check("model_y_data", 32'(bus.y_data), 32'(m_data));
        check("model_y_sel", 32'(bus.y_sel), 32'(m_sel));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] rr_exp[4];
    rr_exp[0] = 8'h11; rr_exp[1] = 8'h22; rr_exp[2] = 8'h33; rr_exp[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      sv[i] = 1'b0;
      sd[i] = 8'h00;
    end
    yr    = 1'b0;
    rst_n = 1'b0;

    // Reset: a pending request must not be granted while rst_n is low
    sv[0] = 1'b1; sd[0] = 8'h99;
    tick(); tick();
    #1;
    check("rst_ready", 32'(rdy), 32'h0);
    check("rst_y_valid", 32'(bus.y_valid), 32'h0);
    check("rst_y_data", 32'(bus.y_data), 32'h0);
    check("rst_y_sel", 32'(bus.y_sel), 32'h0);

    // Single source after reset
    rst_n = 1'b1; sv[0] = 1'b1; sd[0] = 8'h3C; yr = 1'b1;
    #1;
    check("t1_a_ready", 32'(rdy), 32'b0001);
    tick();
    sv[0] = 1'b0;
    #1;
    check("t1_y_valid", 32'(bus.y_valid), 32'h1);
    check("t1_y_data", 32'(bus.y_data), 32'h3C);
    check("t1_y_sel", 32'(bus.y_sel), 32'h0);
    tick(); #1;
    check("t1_drain", 32'(bus.y_valid), 32'h0);

    // All four valid: strict rotation, no idle beats
    do_reset();
    sd[0] = 8'h11; sd[1] = 8'h22; sd[2] = 8'h33; sd[3] = 8'h44;
    for (int i = 0; i < 4; i++) sv[i] = 1'b1;
    yr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(); #1;
      check("rr_y_valid", 32'(bus.y_valid), 32'h1);
      check("rr_y_data", 32'(bus.y_data), 32'(rr_exp[i % 4]));
      check("rr_y_sel", 32'(bus.y_sel), 32'(i % 4));
    end
    for (int i = 0; i < 4; i++) sv[i] = 1'b0;
    tick();

    // Backpressure: C held while B and D wait
    sv[2] = 1'b1; sd[2] = 8'hA5; yr = 1'b0;
    #1;
    check("bp_c_ready", 32'(rdy), 32'b0100);
    tick();
    sv[2] = 1'b0;
    sv[1] = 1'b1; sd[1] = 8'hB1;
    sv[3] = 1'b1; sd[3] = 8'hD1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_hold_data", 32'(bus.y_data), 32'hA5);
      check("bp_hold_sel", 32'(bus.y_sel), 32'h2);
      check("bp_hold_ready", 32'(rdy), 32'h0);
      tick();
    end
    yr = 1'b1;
    #1;
    check("bp_release_ready", 32'(rdy), 32'b1000);
    tick();
    sv[3] = 1'b0;
    #1;
    check("bp_d_data", 32'(bus.y_data), 32'hD1);
    check("bp_d_sel", 32'(bus.y_sel), 32'h3);
    check("bp_b_ready", 32'(rdy), 32'b0010);
    tick();
    sv[1] = 1'b0;
    #1;
    check("bp_b_data", 32'(bus.y_data), 32'hB1);
    check("bp_b_sel", 32'(bus.y_sel), 32'h1);
    tick(); #1;
    check("bp_drain", 32'(bus.y_valid), 32'h0);

    // Wrap-around: D then A, pointer lands on B
    do_reset();
    sv[3] = 1'b1; sd[3] = 8'hDD;
    #1;
    check("wrap_d_ready", 32'(rdy), 32'b1000);
    tick();
    sv[3] = 1'b0;
    sv[0] = 1'b1; sd[0] = 8'hAA;
    #1;
    check("wrap_d_sel", 32'(bus.y_sel), 32'h3);
    check("wrap_a_ready", 32'(rdy), 32'b0001);
    tick();
    sv[1] = 1'b1; sd[1] = 8'hBB;
    #1;
    check("wrap_a_sel", 32'(bus.y_sel), 32'h0);
    check("wrap_a_data", 32'(bus.y_data), 32'hAA);
    check("wrap_ptr_b", 32'(rdy), 32'b0010);
    tick();
    sv[0] = 1'b0; sv[1] = 1'b0;
    #1;
    check("wrap_b_data", 32'(bus.y_data), 32'hBB);
    tick(); #1;
    check("wrap_drain", 32'(bus.y_valid), 32'h0);

    // Reset while a beat is held under backpressure
    sv[0] = 1'b1; sd[0] = 8'h7E; yr = 1'b0;
    tick();
    sv[0] = 1'b0;
    #1;
    check("mid_held_valid", 32'(bus.y_valid), 32'h1);
    check("mid_held_data", 32'(bus.y_data), 32'h7E);
    rst_n = 1'b0; sv[1] = 1'b1; sd[1] = 8'h66;
    #1;
    check("mid_rst_ready", 32'(rdy), 32'h0);
    tick();
    rst_n = 1'b1; sv[1] = 1'b0; yr = 1'b1;
    #1;
    check("mid_y_valid", 32'(bus.y_valid), 32'h0);
    check("mid_y_data", 32'(bus.y_data), 32'h0);
    check("mid_y_sel", 32'(bus.y_sel), 32'h0);
    tick(); tick(); #1;
    check("mid_no_7e", 32'(bus.y_valid), 32'h0);
    for (int i = 0; i < 4; i++) sv[i] = 1'b1;
    #1;
    check("mid_ptr_a", 32'(rdy), 32'b0001);
    for (int i = 0; i < 4; i++) sv[i] = 1'b0;

    // Pass-through replace: drain and reload in the same cycle
    sv[0] = 1'b1; sd[0] = 8'h5A; yr = 1'b1;
    tick();
    sv[0] = 1'b0;
    sv[1] = 1'b1; sd[1] = 8'hB7;
    #1;
    check("pt_b_ready", 32'(rdy), 32'b0010);
    check("pt_prev_data", 32'(bus.y_data), 32'h5A);
    tick();
    sv[1] = 1'b0;
    #1;
    check("pt_y_valid", 32'(bus.y_valid), 32'h1);
    check("pt_y_data", 32'(bus.y_data), 32'hB7);
    check("pt_y_sel", 32'(bus.y_sel), 32'h1);
    tick(); #1;
    check("pt_no_repeat", 32'(bus.y_valid), 32'h0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_mux4.md
Name: rr_mux4

Overview:
- Four-input, single-output arbitrated multiplexer.
- Merges four 8-bit source channels A/B/C/D onto one output channel.
- Tags each output beat with a 2-bit source index, so the 1-to-4 demux downstream can route it back by `sel`.
- Round-robin fairness; valid/ready handshake on every port; one registered output stage.

Parameters:
WIDTH, 8, data width of every channel
NSRC, 4, number of sources; fixed at 4, not to be overridden

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
a_valid  input  1  source A beat available
a_data  input  WIDTH  source A payload
a_ready  output  1  source A beat accepted this cycle
b_valid  input  1  source B beat available
b_data  input  WIDTH  source B payload
b_ready  output  1  source B beat accepted this cycle
c_valid  input  1  source C beat available
c_data  input  WIDTH  source C payload
c_ready  output  1  source C beat accepted this cycle
d_valid  input  1  source D beat available
d_data  input  WIDTH  source D payload
d_ready  output  1  source D beat accepted this cycle
y_valid  output  1  output beat held in register
y_data  output  WIDTH  output payload
y_sel  output  2  source index of y_data: 00=A, 01=B, 10=C, 11=D
y_ready  input  1  downstream accepts beat

Behaviour:
- Reset (rst_n low at a clk edge):
  - y_valid=0, y_data=0, y_sel=0.
  - Priority pointer ptr=0, so A is highest priority.
  - All x_ready=0 while rst_n is low.
  - A beat held in the output register when reset hits is discarded; no completion.
- Output register states:
  - EMPTY (y_valid=0) and FULL (y_valid=1).
  - load = (!y_valid || y_ready) && any x_valid.
  - EMPTY -> FULL on load.
  - FULL -> EMPTY when y_ready and no x_valid.
  - FULL -> FULL when y_ready and load (back-to-back beat).
  - FULL holds when !y_ready: y_data and y_sel stable, no x_ready asserted.
- Arbitration (combinational, same cycle):
  - Grant goes to the first valid source scanning ptr, ptr+1, ... modulo 4.
  - Exactly one x_ready is asserted, only for the granted source, and only when (!y_valid || y_ready).
  - x_ready never depends on that source's own x_valid beyond the grant, so there is no combinational loop to upstream.
- Transfer:
  - A source handshake completes when x_valid && x_ready.
  - On that edge y_data <= x_data, y_sel <= index, y_valid <= 1.
  - Latency is one cycle from the source handshake to y_valid.
  - Throughput is one beat per cycle when y_ready is held high.
- Pointer update: on each completed source handshake, ptr <= granted index + 1 (mod 4). Otherwise ptr is unchanged.
- Fairness: with all four valid continuously and y_ready=1, the grant order is A,B,C,D,A,... Any valid source waits at most 3 beats.
- Simultaneous events: y_ready and a new load in the same cycle is a pass-through replace. No bubble, no duplicate.
- Source rules:
  - A source must keep x_valid and x_data stable until its handshake.
  - A source that deasserts x_valid before its handshake is simply skipped; no error reporting.
- Widths: y_sel is a 2-bit encoding of the grant. Pointer arithmetic wraps mod 4; 3+1 = 0.

Decomposition:
- Shared package holds:
  - WIDTH default.
  - Source index constants SRC_A=2'd0, SRC_B=2'd1, SRC_C=2'd2, SRC_D=2'd3. The 1-to-4 demux uses the same encoding for `sel`.
- One sub-module, rr_arb4:
  - Inputs: 4-bit request vector and 2-bit ptr.
  - Outputs: one-hot grant, 2-bit grant index, any-request flag.
  - Purely combinational.
- Top level holds the output register, the ptr register and the handshake logic.

Test Plan:
- Reset then single source: a_valid=1, a_data=8'h3C, y_ready=1 → a_ready=1 in the first cycle; next cycle y_valid=1, y_data=8'h3C, y_sel=00.
- All four valid, data A=11, B=22, C=33, D=44, y_ready=1 for 8 cycles → y_data sequence 11,22,33,44,11,22,33,44; y_sel 00,01,10,11 repeating; no idle cycles.
- Backpressure:
  - Load C=8'hA5, then hold y_ready=0 for 5 cycles with B and D valid.
  - Required: y_data stays A5 with y_sel=10, and every x_ready=0 throughout.
  - On release, the next beat is D (ptr=3), then B.
- Wrap-around: only d_valid then a_valid asserted, in successive cycles → ptr moves 0→0 (D granted)→1; the A beat is granted and y_sel=00 follows y_sel=11.
- Reset mid-operation: y_valid=1 holding 8'h7E with y_ready=0; pull rst_n low for one edge → y_valid=0, y_data=0, y_sel=0, ptr=0; the 7E beat is never delivered.
- Pass-through: y_valid=1, y_ready=1 and b_valid=1 in the same cycle → b_ready=1; next cycle y_data=b_data and y_sel=01, with no bubble and no repeat of the previous beat.
